// File: rtl/sb_slice.sv
// rtl/sb_slice.sv - sb bus register slice with per-channel bypass, forward-register or skid-buffer stages
// sb_stage is one valid/ready stage; sb_slice wires four of them onto the AR, R, W and B channels.

module sb_stage #(
  parameter int MODE = 2,
  parameter int PW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_data,
  output logic          idle
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  generate
    if (MODE == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dn_valid = up_valid;
      assign dn_data  = up_data;
      assign up_ready = dn_ready;
      assign idle     = 1'b1;
    end else if (MODE == 1) begin : g_fwd
      logic          full_q;
      logic [PW-1:0] data_q;
      logic          up_hs;
      logic          dn_hs;

      assign up_ready = ~full_q | dn_ready;
      assign up_hs    = up_valid & up_ready;
      assign dn_hs    = full_q & dn_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          full_q <= 1'b0;
          data_q <= '0;
        end else if (up_hs) begin
          full_q <= 1'b1;
          data_q <= up_data;
        end else if (dn_hs) begin
          full_q <= 1'b0;
        end
      end

      assign dn_valid = full_q;
      assign dn_data  = data_q;
      assign idle     = ~full_q;
    end else begin : g_skid
      state_t        state_q, state_d;
      logic          ready_q;
      logic [PW-1:0] main_q, main_d;
      logic [PW-1:0] skid_q, skid_d;
      logic          main_full;
      logic          up_hs;
      logic          dn_hs;

      assign main_full = (state_q != EMPTY);
      assign up_hs     = up_valid & ready_q;
      assign dn_hs     = main_full & dn_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (up_hs) begin
              state_d = ONE;
              main_d  = up_data;
            end
          end
          ONE: begin
            if (up_hs && dn_hs) begin
              main_d = up_data;
            end else if (up_hs) begin
              state_d = TWO;
              skid_d  = up_data;
            end else if (dn_hs) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            // ready_q is low here, so only the downstream side can move
            if (dn_hs) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          ready_q <= (state_d != TWO);
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      assign up_ready = ready_q;
      assign dn_valid = main_full;
      assign dn_data  = main_q;
      assign idle     = ~main_full;
    end
  endgenerate

endmodule

module sb_slice #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int AR_MODE = 2,
  parameter int R_MODE  = 2,
  parameter int W_MODE  = 2,
  parameter int B_MODE  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sb_arvalid_m,
  output logic            sb_arready_m,
  input  logic [AW-1:0]   sb_araddr_m,
  output logic            sb_rvalid_m,
  input  logic            sb_rready_m,
  output logic [DW-1:0]   sb_rdata_m,
  input  logic            sb_wvalid_m,
  output logic            sb_wready_m,
  input  logic [AW-1:0]   sb_waddr_m,
  input  logic [DW-1:0]   sb_wdata_m,
  input  logic [DW/8-1:0] sb_wstrb_m,
  output logic            sb_bvalid_m,
  input  logic            sb_bready_m,
  output logic            sb_bresp_m,
  output logic            sb_arvalid_s,
  input  logic            sb_arready_s,
  output logic [AW-1:0]   sb_araddr_s,
  input  logic            sb_rvalid_s,
  output logic            sb_rready_s,
  input  logic [DW-1:0]   sb_rdata_s,
  output logic            sb_wvalid_s,
  input  logic            sb_wready_s,
  output logic [AW-1:0]   sb_waddr_s,
  output logic [DW-1:0]   sb_wdata_s,
  output logic [DW/8-1:0] sb_wstrb_s,
  input  logic            sb_bvalid_s,
  output logic            sb_bready_s,
  input  logic            sb_bresp_s,
  output logic            idle
);

  localparam int SW  = DW / 8;
  localparam int WPW = AW + DW + SW;

  logic           ar_idle, r_idle, w_idle, b_idle;
  logic [WPW-1:0] w_dn_data;

  sb_stage #(.MODE(AR_MODE), .PW(AW)) u_ar (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (sb_arvalid_m),
    .up_ready (sb_arready_m),
    .up_data  (sb_araddr_m),
    .dn_valid (sb_arvalid_s),
    .dn_ready (sb_arready_s),
    .dn_data  (sb_araddr_s),
    .idle     (ar_idle)
  );

  // R and B travel slave -> master, so the slave side is upstream
  sb_stage #(.MODE(R_MODE), .PW(DW)) u_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (sb_rvalid_s),
    .up_ready (sb_rready_s),
    .up_data  (sb_rdata_s),
    .dn_valid (sb_rvalid_m),
    .dn_ready (sb_rready_m),
    .dn_data  (sb_rdata_m),
    .idle     (r_idle)
  );

  sb_stage #(.MODE(W_MODE), .PW(WPW)) u_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (sb_wvalid_m),
    .up_ready (sb_wready_m),
    .up_data  ({sb_waddr_m, sb_wdata_m, sb_wstrb_m}),
    .dn_valid (sb_wvalid_s),
    .dn_ready (sb_wready_s),
    .dn_data  (w_dn_data),
    .idle     (w_idle)
  );

  assign {sb_waddr_s, sb_wdata_s, sb_wstrb_s} = w_dn_data;

  sb_stage #(.MODE(B_MODE), .PW(1)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (sb_bvalid_s),
    .up_ready (sb_bready_s),
    .up_data  (sb_bresp_s),
    .dn_valid (sb_bvalid_m),
    .dn_ready (sb_bready_m),
    .dn_data  (sb_bresp_m),
    .idle     (b_idle)
  );

  assign idle = ar_idle & r_idle & w_idle & b_idle;

endmodule

// File: doc/sb_slice.md
Name: sb_slice

Overview:
- Parametrised register slice for the sb bus (AR, R, W, B channels), inserted between a bus master and a slave or interconnect to cut timing paths.
- Each channel independently selects bypass, forward-register or full skid-buffer mode.
- Address and data widths are generic.
- An idle status output tells power/clock control that no transfer is held inside the slice.

Parameters:
- AW, 32, address width of sb_araddr/sb_waddr.
- DW, 32, data width of sb_rdata/sb_wdata; must be a multiple of 8; strobe width is DW/8.
- AR_MODE, 2, AR channel mode: 0=bypass, 1=forward register, 2=skid buffer; values >2 behave as 2.
- R_MODE, 2, R channel mode, same encoding.
- W_MODE, 2, W channel mode, same encoding.
- B_MODE, 2, B channel mode, same encoding.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sb_arvalid_m in 1; sb_arready_m out 1; sb_araddr_m in AW: master read-address channel.
- sb_rvalid_m out 1; sb_rready_m in 1; sb_rdata_m out DW: master read-data channel.
- sb_wvalid_m in 1; sb_wready_m out 1; sb_waddr_m in AW; sb_wdata_m in DW; sb_wstrb_m in DW/8: master write channel.
- sb_bvalid_m out 1; sb_bready_m in 1; sb_bresp_m out 1: master write-response channel.
- sb_arvalid_s out 1; sb_arready_s in 1; sb_araddr_s out AW: slave read-address channel.
- sb_rvalid_s in 1; sb_rready_s out 1; sb_rdata_s in DW: slave read-data channel.
- sb_wvalid_s out 1; sb_wready_s in 1; sb_waddr_s out AW; sb_wdata_s out DW; sb_wstrb_s out DW/8: slave write channel.
- sb_bvalid_s in 1; sb_bready_s out 1; sb_bresp_s in 1: slave write-response channel.
- idle  out  1  1 = no registered stage holds a valid beat.

Behaviour:
- Generic stage: upstream (up) to downstream (dn).
  - AR and W flow m->s; R and B flow s->m.
  - Payload is all non-handshake signals of the channel, concatenated.
  - Every stage uses its own handshake signals only; no channel's ready or valid affects another channel.
- Beat transfer occurs when valid & ready on a side. Beats leave in arrival order; none are dropped or duplicated.
- Valid rule: once dn_valid is high, it and its payload stay stable until dn_ready.
- Mode 0 (bypass): pure wires, zero latency, no flops; the channel contributes 1 to idle.
- Mode 1 (forward register), one entry:
  - up_ready = ~full | dn_ready. This is a combinational ready path dn->up.
  - On an up handshake: full<=1, payload<=up payload.
  - On a dn handshake without an up handshake: full<=0.
  - Simultaneous up and dn handshake: full stays 1 and payload is replaced by the new beat.
  - dn_valid = full; dn payload = registered payload. Latency 1 cycle; throughput 1 beat/cycle.
- Mode 2 (skid buffer), two entries (main, skid); no combinational path between sides.
  - up_ready = ~skid_full, driven from a flop.
  - dn_valid = main_full; dn payload = main register.
  - States: EMPTY (main=0, skid=0), ONE (main=1, skid=0), TWO (main=1, skid=1).
  - EMPTY: up handshake -> ONE, main<=up payload.
  - ONE: up handshake only -> TWO, skid<=up payload.
  - ONE: dn handshake only -> EMPTY.
  - ONE: both handshakes -> ONE, main<=up payload.
  - TWO: up_ready=0, so no up handshake is possible. dn handshake -> ONE, main<=skid.
  - Latency 1 cycle; sustained 1 beat/cycle when dn_ready stays high.
- Reset (async assert; release takes effect on the next clk edge):
  - All full/state flops clear: state EMPTY, valids 0.
  - Payload registers reset to 0, so all m/s payload outputs of registered channels read 0.
  - Registered-mode up_ready outputs read 1 during and after reset; idle=1.
  - Reset mid-transfer discards held beats without emitting them.
- Payload registers load only on an up handshake, never on up_valid alone or on ready alone.
- idle = AND over registered channels of ~main_full (mode 1: ~full). It is combinational from flops only.
- No address decode or response generation; bresp passes through unchanged.

Test Plan:
- All modes=2, DW=32: issue 8 AR beats addr 0x100..0x11C back-to-back with sb_arready_s=1 -> 8 beats on the slave side in order, each 1 cycle later; sb_arready_m high throughout; idle=0 while beats in flight and 1 one cycle after the last.
- Mode 2 W channel, sb_wready_s=0: send wdata 0xA, 0xB, 0xC -> sb_wready_m drops the cycle after 0xB is accepted; 0xC is held at the master. Raise sb_wready_s -> slave sees 0xA, 0xB, 0xC in order with no gap.
- Mode 1 R channel: sb_rvalid_s with rdata 0x55 and sb_rready_m toggling 1,0,1 -> sb_rready_s follows ~full|sb_rready_m in the same cycle; 0x55 is held stable while sb_rready_m=0.
- Mode 0 B channel: sb_bvalid_s=1, bresp=1 -> sb_bvalid_m=1 and sb_bresp_m=1 in the same cycle; sb_bready_s equals sb_bready_m.
- Simultaneous handshakes: mode 1 and mode 2 channels with continuous up/dn handshakes for 16 cycles -> throughput 16 beats; state stays ONE (mode 2).
- Reset with mode 2 AR in TWO (addresses 0x20 and 0x24 held) -> sb_arvalid_s=0 and sb_araddr_s=0 immediately on reset; sb_arready_m=1; after release no stale beat appears.
